// File: rtl/vc_sram_arb_pkg.sv
// rtl/vc_sram_arb_pkg.sv - shared types and constants for the two-port SRAM arbiter
// Contents: state_t FSM encoding, request type constants.
package vc_sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RESP_FIRST,
      RESP_HOLD
   } state_t;

   localparam logic c_req_read  = 1'b0;
   localparam logic c_req_write = 1'b1;

endpackage

// File: rtl/vc_sram_arbiter_2port_sram.sv
// rtl/vc_sram_arbiter_2port_sram.sv - single-port synchronous SRAM with byte-enable writes
// Ports: clk; read_en/read_addr -> read_data (registered, valid the cycle after read_en);
//        write_en/write_byte_en/write_addr/write_data (written at the clock edge).
module vc_SynchronousSRAM_1rw #(
   parameter  int p_data_nbits  = 32,
   parameter  int p_num_entries = 256,
   localparam int c_addr_nbits  = $clog2(p_num_entries),
   localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
   input  logic                     clk,
   input  logic                     read_en,
   input  logic [c_addr_nbits-1:0]  read_addr,
   output logic [p_data_nbits-1:0]  read_data,
   input  logic                     write_en,
   input  logic [c_data_nbytes-1:0] write_byte_en,
   input  logic [c_addr_nbits-1:0]  write_addr,
   input  logic [p_data_nbits-1:0]  write_data
);

   logic [p_data_nbits-1:0] mem [p_num_entries];

   // read_data holds its value when read_en is low; the arbiter relies on
   // this to capture the word one cycle late into its hold register.
   always_ff @(posedge clk) begin
      if (read_en) begin
         read_data <= mem[read_addr];
      end
      if (write_en) begin
         for (int i = 0; i < p_data_nbits; i++) begin
            if (write_byte_en[i/8]) begin
               mem[write_addr][i] <= write_data[i];
            end
         end
      end
   end

endmodule

// File: rtl/vc_sram_arbiter_2port.sv
// rtl/vc_sram_arbiter_2port.sv - round-robin arbiter sharing one SRAM between two val/rdy requesters
// Ports: clk, reset (sync, active-high);
//        req_val/req_rdy/req_type/req_addr/req_data/req_wben  - packed per-requester request channels;
//        resp_val/resp_rdy/resp_type/resp_data                - packed per-requester response channels.
module vc_sram_arbiter_2port
   import vc_sram_arb_pkg::*;
#(
   parameter  int p_data_nbits  = 32,
   parameter  int p_num_entries = 256,
   localparam int c_addr_nbits  = $clog2(p_num_entries),
   localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 req_val,
   output logic [1:0]                 req_rdy,
   input  logic [1:0]                 req_type,
   input  logic [2*c_addr_nbits-1:0]  req_addr,
   input  logic [2*p_data_nbits-1:0]  req_data,
   input  logic [2*c_data_nbytes-1:0] req_wben,
   output logic [1:0]                 resp_val,
   input  logic [1:0]                 resp_rdy,
   output logic [1:0]                 resp_type,
   output logic [2*p_data_nbits-1:0]  resp_data
);

   state_t                  state;
   logic                    prio;
   logic                    owner;
   logic                    rtype;
   logic [p_data_nbits-1:0] hold;
   logic [p_data_nbits-1:0] sram_rdata;

   logic                     active;
   logic                     fire;
   logic                     can_accept;
   logic                     g;
   logic                     accept;
   logic                     g_type;
   logic [c_addr_nbits-1:0]  g_addr;
   logic [p_data_nbits-1:0]  g_data;
   logic [c_data_nbytes-1:0] g_wben;
   logic [p_data_nbits-1:0]  resp_word;

   assign active     = (state != IDLE) && !reset;
   assign fire       = active && resp_rdy[owner];
   assign can_accept = !reset && ((state == IDLE) || fire);

   // Grant favours prio when it is requesting; with no requests the grant
   // still points at prio so req_rdy never looks at the other requester's val.
   always_comb begin
      g = prio;
      if (!req_val[prio] && req_val[~prio]) begin
         g = ~prio;
      end
   end

   assign accept = can_accept && req_val[g];
   assign g_type = req_type[g];
   assign g_addr = g ? req_addr[2*c_addr_nbits-1:c_addr_nbits]   : req_addr[c_addr_nbits-1:0];
   assign g_data = g ? req_data[2*p_data_nbits-1:p_data_nbits]   : req_data[p_data_nbits-1:0];
   assign g_wben = g ? req_wben[2*c_data_nbytes-1:c_data_nbytes] : req_wben[c_data_nbytes-1:0];

   always_comb begin
      req_rdy = 2'b00;
      if (can_accept) begin
         req_rdy[g] = 1'b1;
      end
   end

   vc_SynchronousSRAM_1rw #(
      .p_data_nbits  (p_data_nbits),
      .p_num_entries (p_num_entries)
   ) sram (
      .clk           (clk),
      .read_en       (accept && (g_type == c_req_read)),
      .read_addr     (g_addr),
      .read_data     (sram_rdata),
      .write_en      (accept && (g_type == c_req_write)),
      .write_byte_en (g_wben),
      .write_addr    (g_addr),
      .write_data    (g_data)
   );

   // First response cycle reads the SRAM output directly; once stalled the
   // word lives in hold because the SRAM may be reused by a later accept.
   always_comb begin
      resp_word = '0;
      if (active && (rtype == c_req_read)) begin
         resp_word = (state == RESP_FIRST) ? sram_rdata : hold;
      end
   end

   always_comb begin
      resp_val  = 2'b00;
      resp_type = 2'b00;
      resp_data = '0;
      if (active) begin
         resp_val[owner]  = 1'b1;
         resp_type[owner] = rtype;
         resp_data        = owner ? {resp_word, {p_data_nbits{1'b0}}}
                                  : {{p_data_nbits{1'b0}}, resp_word};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         prio  <= 1'b0;
         owner <= 1'b0;
         rtype <= 1'b0;
         hold  <= '0;
      end else begin
         if (accept) begin
            state <= RESP_FIRST;
            owner <= g;
            rtype <= g_type;
            prio  <= ~g;
         end else if (fire) begin
            state <= IDLE;
         end else if (state == RESP_FIRST) begin
            state <= RESP_HOLD;
            hold  <= sram_rdata;
         end
      end
   end

endmodule

// File: doc/vc_sram_arbiter_2port.md
# vc_sram_arbiter_2port

Round-robin arbiter and sequencer that shares one `vc_SynchronousSRAM_1rw` between two requesters over latency-insensitive val/rdy request and response interfaces. It accepts at most one request per cycle and drives the SRAM read or write in the accept cycle. It returns each response to the granted requester, holding read data until that requester takes it. It sits between cache/accelerator clients and a shared scratchpad SRAM.

## Interface
Parameters:
- `p_data_nbits`, 32, SRAM word width.
- `p_num_entries`, 256, SRAM depth.
- `c_addr_nbits`, `$clog2(p_num_entries)`, derived address width.
- `c_data_nbytes`, `(p_data_nbits+7)/8`, derived byte-enable width.

Ports. Clock and reset: one clock; reset is synchronous and active-high. Arrays below are packed, and index i ∈ {0,1} is the requester.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous active-high reset.
- `req_val`  in  2  request valid, one bit per requester.
- `req_rdy`  out  2  request ready, one bit per requester.
- `req_type`  in  2  per requester: 0 = read, 1 = write.
- `req_addr`  in  2×c_addr_nbits  word address.
- `req_data`  in  2×p_data_nbits  write data.
- `req_wben`  in  2×c_data_nbytes  write byte enables.
- `resp_val`  out  2  response valid.
- `resp_rdy`  in  2  response ready.
- `resp_type`  out  2  echo of the request type.
- `resp_data`  out  2×p_data_nbits  read data; 0 for writes.

## Operation
- FSM states:
  - IDLE: no response outstanding.
  - RESP_FIRST: response outstanding; read data comes straight from the SRAM output.
  - RESP_HOLD: response outstanding; read data comes from the internal hold register.
- `can_accept` = (state==IDLE) OR (the owner's response handshake, `resp_val[owner] && resp_rdy[owner]`, fires this cycle).
- Grant when `can_accept`:
  - If both requesters are valid, grant the one selected by `prio`.
  - If only one is valid, grant it.
  - `req_rdy[g]`=1 only for the granted requester; the other's `req_rdy`=0.
  - `req_rdy` must not depend on `req_val[other]` beyond selecting the grant.
- Accept action:
  - Read: `read_en`=1 to the SRAM.
  - Write: `write_en`=1 with `write_byte_en`=`req_wben[g]`.
  - In both cases: latch owner=g and type; set `prio` = ~g; next state = RESP_FIRST.
- RESP_FIRST:
  - `resp_val[owner]`=1. For reads, `resp_data[owner]` = SRAM `read_data`; for writes it is 0.
  - Response fires and a new request is accepted: stay in RESP_FIRST.
  - Response fires, no new request: go to IDLE.
  - No fire: capture SRAM `read_data` into the hold register and go to RESP_HOLD.
- RESP_HOLD:
  - `resp_val[owner]`=1 and `resp_data` = hold register.
  - Response fires: go to RESP_FIRST if a new request is accepted that cycle, else IDLE.
- Response signals of the non-owner: `resp_val`=0, `resp_data`=0, `resp_type`=0.
- A write whose `wben` is all zero is still accepted and acked; the SRAM is unchanged.
- There is no address forwarding. A same-address read accepted the cycle after a write returns the new data, because the SRAM writes at the clock edge.
- `prio` updates only on an accept. Idle cycles do not rotate it.

## Timing
- Reset (synchronous) sets: state=IDLE, `prio`=0, owner=0, hold register=0, `req_rdy`=2'b00, `resp_val`=2'b00, `resp_data`=0, `resp_type`=0.
- The cycle after reset deasserts: `req_rdy[i]` follows `req_val` and the grant rule.
- Latency: a request accepted at edge N produces `resp_val` in cycle N+1, the cycle after the accept.
- Throughput: one transaction per cycle when the response is drained immediately.
- Backpressure: responses stall indefinitely. `resp_val` and `resp_data` stay stable until the response fires.
- Reset asserted mid-transaction discards the outstanding response. No `resp_val` pulse follows.
- Simultaneous events handled in one cycle: a response fires and a new accept occurs, possibly to the other requester. The old response uses the current SRAM output or hold register; the new accept drives the SRAM in that same cycle.

## Structure
- Shared package `vc_sram_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, RESP_FIRST, RESP_HOLD}` state type.
  - Constants `c_req_read`=0 and `c_req_write`=1.
- Sub-module: one `vc_SynchronousSRAM_1rw` instance, `sram`, driven with `read_addr`=`write_addr`=`req_addr[g]`.
- The arbiter logic (the `prio` register plus grant mux) is inline. No separate module.

## Test plan
- Single requester 0: write addr 3 = 'haaaa with wben 'b11, then read addr 3 → write ack `resp_type`=1, `resp_data`=0; read `resp_data[0]`='haaaa, one cycle after the accept.
- Both requesters valid every cycle, both with `resp_rdy`=1 and reads of addr 0/1 (preloaded 'h1111/'h2222) → grants alternate 0,1,0,1; `resp_val` appears every cycle at the correct index.
- Requester 0 reads addr 2 ('hcccc) with `resp_rdy[0]`=0 for 3 cycles → `resp_val[0]` held at 'hcccc through the RESP_HOLD path; `req_rdy`=00 during the stall; one response delivered when `resp_rdy[0]` rises.
- Partial writes: 'haaaa with wben 'b10, then 'hdddd with wben 'b01, then wben 'b00 with 'h0123, each followed by a read of addr 0 → reads return 'haa00, 'haadd, 'haadd.
- Reset asserted while a response is stalled → the next cycle has `resp_val`=00 and `req_rdy`=00; after reset deasserts, requester 1 alone is granted immediately.
- Back-to-back write then read of the same address (addr 4 = 'heeee) from different requesters in consecutive cycles → the read returns 'heeee.
